inst_fetch_queue: RTL and testbench

//  Next-generation instruction fetch stage: a prefetching front end that keeps up
//  to MAX_OUT reads in flight on the instruction bus and buffers returned words in
//  a DEPTH-entry queue. Decode consumes entries through a valid/ready handshake

---
 rtl/inst_fetch_queue_pkg.sv | 10 +
 rtl/ifq_fifo.sv | 49 ++++
 rtl/inst_fetch_queue.sv | 90 +++++++++
 tb/tb_inst_fetch_queue.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_queue_pkg.sv
// Shared widths and the queue entry layout for the instruction fetch front end.
package inst_fetch_queue_pkg;
  localparam int IFQ_PC_W   = 30;
  localparam int IFQ_INST_W = 32;

  typedef struct packed {
    logic [IFQ_PC_W-1:0]   pc;
    logic [IFQ_INST_W-1:0] inst;
  } ifq_entry_t;
endpackage

// File: rtl/ifq_fifo.sv
// Synchronous FIFO of fetched entries; pointers carry a wrap bit so full/empty need no extra flag.
module ifq_fifo
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  ifq_entry_t             wdata,
  output ifq_entry_t             rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);
  localparam int AW = $clog2(DEPTH);

  ifq_entry_t     mem [DEPTH];
  logic [AW:0]    wr_ptr, rd_ptr;

  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Full + push + pop overwrites the slot being read out this same cycle.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      assert (!(push && full && !pop)) else $error("ifq_fifo overflow");
      assert (!(pop && empty))         else $error("ifq_fifo underflow");
    end
  end
endmodule

// File: rtl/inst_fetch_queue.sv
// Prefetching fetch stage: credit-limited I-bus reads feed a queue drained by decode via valid/ready.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int                  DEPTH    = 4,
  parameter int                  MAX_OUT  = 2,
  parameter logic [IFQ_PC_W-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_i,
  input  logic [IFQ_PC_W-1:0]   redirect_pc_i,
  output logic [IFQ_PC_W-1:0]   mem_addr_o,
  output logic                  mem_read_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_ready_i,
  input  logic [IFQ_INST_W-1:0] mem_dataQ_i,
  output logic [3:0]            mem_byteSel_o,
  output logic                  inst_valid_o,
  output logic [IFQ_PC_W-1:0]   inst_pc_o,
  output logic [IFQ_INST_W-1:0] inst_o,
  input  logic                  inst_ready_i,
  output logic                  stop_o
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int SW = CW + OW + 1;

  logic [IFQ_PC_W-1:0] fetch_pc, resp_pc;
  logic [OW-1:0]       outstanding, drop_cnt;
  logic [CW-1:0]       count;
  logic [SW-1:0]       live;
  logic                empty, full, accept, push, pop;
  ifq_entry_t          wentry, head;

  // Live entries = reads that will still land in the queue plus what is already queued.
  assign live       = SW'(outstanding) - SW'(drop_cnt) + SW'(count);
  assign mem_read_o = !rst && !redirect_i && (outstanding < OW'(MAX_OUT)) && (live < SW'(DEPTH));
  assign mem_addr_o = fetch_pc;
  assign mem_byteSel_o = 4'b1111;
  assign accept = mem_read_o && mem_gnt_i;
  assign push   = mem_ready_i && (drop_cnt == '0) && !redirect_i;

  assign inst_valid_o = !rst && !empty && !redirect_i;
  assign pop          = inst_valid_o && inst_ready_i;
  assign stop_o       = !inst_valid_o && !rst;
  assign inst_pc_o    = head.pc;
  assign inst_o       = head.inst;
  assign wentry       = '{pc: resp_pc, inst: mem_dataQ_i};

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (redirect_i) begin
      // Everything still in flight after this cycle belongs to the old stream.
      fetch_pc    <= redirect_pc_i;
      resp_pc     <= redirect_pc_i;
      outstanding <= outstanding - OW'(mem_ready_i);
      drop_cnt    <= outstanding - OW'(mem_ready_i);
    end else begin
      if (accept) fetch_pc <= fetch_pc + IFQ_PC_W'(1);
      if (push)   resp_pc  <= resp_pc + IFQ_PC_W'(1);
      outstanding <= outstanding + OW'(accept) - OW'(mem_ready_i);
      if (mem_ready_i && drop_cnt != '0) drop_cnt <= drop_cnt - OW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(mem_ready_i && outstanding == '0)) else $error("response with nothing outstanding");
      assert (!(push && full && !pop))            else $error("fetch queue overflow");
    end
  end

  ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_i),
    .wdata (wentry),
    .rdata (head),
    .count (count),
    .empty (empty),
    .full  (full)
  );
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed + random checks of the fetch queue against a bus model and an expected-PC scoreboard.
module tb_inst_fetch_queue;
  import inst_fetch_queue_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  redirect_i;
  logic [IFQ_PC_W-1:0]   redirect_pc_i;
  logic [IFQ_PC_W-1:0]   mem_addr_o;
  logic                  mem_read_o;
  logic                  mem_gnt_i;
  logic                  mem_ready_i;
  logic [IFQ_INST_W-1:0] mem_dataQ_i;
  logic [3:0]            mem_byteSel_o;
  logic                  inst_valid_o;
  logic [IFQ_PC_W-1:0]   inst_pc_o;
  logic [IFQ_INST_W-1:0] inst_o;
  logic                  inst_ready_i;
  logic                  stop_o;

  int checks = 0;
  int errors = 0;
  int npop   = 0;
  logic [IFQ_PC_W-1:0] pending[$];  // bus: accepted addresses awaiting response
  logic [IFQ_PC_W-1:0] sb[$];       // expected delivery order in current stream
  logic [IFQ_PC_W-1:0] exp_fetch;
  logic [IFQ_PC_W-1:0] last_pop;

  inst_fetch_queue #(.DEPTH(4), .MAX_OUT(2), .RESET_PC('0)) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .mem_addr_o    (mem_addr_o),
    .mem_read_o    (mem_read_o),
    .mem_gnt_i     (mem_gnt_i),
    .mem_ready_i   (mem_ready_i),
    .mem_dataQ_i   (mem_dataQ_i),
    .mem_byteSel_o (mem_byteSel_o),
    .inst_valid_o  (inst_valid_o),
    .inst_pc_o     (inst_pc_o),
    .inst_o        (inst_o),
    .inst_ready_i  (inst_ready_i),
    .stop_o        (stop_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [IFQ_PC_W-1:0] a);
    return {a[15:0], ~a[15:0]} ^ {2'b10, a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive, sample 2ns later, update models, advance past the edge.
  task automatic step(input bit gnt, input bit rdy_en, input bit irdy, input bit redir,
                      input logic [IFQ_PC_W-1:0] rpc);
    bit rdy;
    logic [IFQ_PC_W-1:0] pc;
    rdy = rdy_en && (pending.size() > 0);
    mem_gnt_i     = gnt;
    mem_ready_i   = rdy;
    mem_dataQ_i   = rdy ? mem_word(pending[0]) : 32'h0;
    inst_ready_i  = irdy;
    redirect_i    = redir;
    redirect_pc_i = rpc;
    #2;
    chk("stop", 64'(stop_o), 64'(!inst_valid_o));
    if (redir) begin
      chk("redir_valid", 64'(inst_valid_o), 0);
      chk("redir_read", 64'(mem_read_o), 0);
    end
    if (inst_valid_o && irdy) begin
      if (sb.size() == 0) chk("pop_unexpected", 64'(inst_valid_o), 0);
      else begin
        pc = sb.pop_front();
        chk("pop_pc", 64'(inst_pc_o), 64'(pc));
        chk("pop_inst", 64'(inst_o), 64'(mem_word(pc)));
        last_pop = inst_pc_o;
        npop++;
      end
    end
    if (rdy) void'(pending.pop_front());
    if (mem_read_o && gnt) begin
      chk("inflight", 64'(pending.size() < 2), 1);
      chk("addr", 64'(mem_addr_o), 64'(exp_fetch));
      pending.push_back(mem_addr_o);
      sb.push_back(exp_fetch);
      exp_fetch = exp_fetch + 1'b1;
    end
    if (redir) begin
      sb.delete();
      exp_fetch = rpc;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_gnt_i = 1'b1; mem_ready_i = 1'b0; mem_dataQ_i = '0;
    inst_ready_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_read", 64'(mem_read_o), 0);
    chk("rst_valid", 64'(inst_valid_o), 0);
    chk("rst_stop", 64'(stop_o), 0);
    rst = 1'b0;
    pending.delete();
    sb.delete();
    exp_fetch = '0;
    #1;
  endtask

  initial begin
    int o;
    int p0;
    // 1: streaming after reset
    do_reset();
    chk("t1_addr0", 64'(mem_addr_o), 0);
    chk("t1_read", 64'(mem_read_o), 1);
    chk("t1_bytesel", 64'(mem_byteSel_o), 64'hF);
    repeat (20) step(1, 1, 1, 0, '0);
    chk("t1_progress", 64'(npop >= 15), 1);

    // 2: decode stalled -> queue fills to DEPTH and fetch stops
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 0, 0, '0);
      if (inst_valid_o) chk("t2_hold", 64'(inst_pc_o), 0);
    end
    chk("t2_valid", 64'(inst_valid_o), 1);
    chk("t2_read", 64'(mem_read_o), 0);
    chk("t2_queued", 64'(sb.size()), 4);
    chk("t2_inflight", 64'(pending.size()), 0);
    p0 = npop;
    repeat (8) step(1, 1, 1, 0, '0);
    chk("t2_drained", 64'(npop - p0 >= 4), 1);
    chk("t2_resume", 64'(exp_fetch >= 5), 1);

    // 3: redirect with pc 8,9 outstanding
    do_reset();
    for (int k = 0; k < 100 && exp_fetch != 8; k++) step(1, 1, 1, 0, '0);
    for (int k = 0; k < 20 && pending.size() != 0; k++) step(0, 1, 1, 0, '0);
    for (int k = 0; k < 20 && exp_fetch != 10; k++) step(1, 0, 1, 0, '0);
    chk("t3_pending", 64'(pending.size()), 2);
    step(1, 0, 1, 1, 30'h100);
    p0 = npop;
    repeat (12) step(1, 1, 1, 0, '0);
    chk("t3_delivered", 64'(npop - p0 >= 4), 1);

    // 4: redirect coinciding with a response and a decode accept
    for (int k = 0; k < 20 && !(pending.size() > 0 && inst_valid_o); k++) step(1, 1, 1, 0, '0);
    o = pending.size();
    step(1, 1, 1, 1, 30'h200);
    chk("t4_drop_cnt", 64'(dut.drop_cnt), 64'(o - 1));
    chk("t4_valid_after", 64'(inst_valid_o), 0);
    p0 = npop;
    repeat (12) step(1, 1, 1, 0, '0);
    chk("t4_delivered", 64'(npop - p0 >= 4), 1);

    // 5: PC wraps at the top of the address space
    step(1, 1, 1, 1, 30'h3FFFFFFF);
    repeat (12) step(1, 1, 1, 0, '0);
    chk("t5_wrap", 64'(last_pop < 30'd20), 1);

    // 6: random traffic, then drain
    for (int i = 0; i < 10000; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 63) == 0, IFQ_PC_W'($urandom()));
    for (int k = 0; k < 200 && (pending.size() != 0 || sb.size() != 0); k++) step(0, 1, 1, 0, '0);
    chk("t6_sb_empty", 64'(sb.size()), 0);
    chk("t6_bus_empty", 64'(pending.size()), 0);
    chk("t6_pops", 64'(npop > 1000), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
